// File: rtl/bus_pkg.sv
// Shared definitions for the serial-bus arbiter: FSM encodings, slave select
// codes, owner identifiers and the serial address widths.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_CONNECT = 3'd2,
    ST_ERROR   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam logic [1:0] SEL_S1  = 2'b00;
  localparam logic [1:0] SEL_S2  = 2'b01;
  localparam logic [1:0] SEL_S3  = 2'b10;
  localparam logic [1:0] SEL_BAD = 2'b11;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_M1   = 2'd1;
  localparam logic [1:0] OWNER_M2   = 2'd2;

  // Master address = 2-bit select prefix + slave address.
  localparam int MADDR_W = 14;
  localparam int SADDR_W = 12;

endpackage

// File: rtl/rr_picker.sv
// Two-way round-robin choice: a lone requester wins, a tie goes to the master
// that was not served last. grant_id 0 = m1, 1 = m2.
module rr_picker (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_id
);

  always_comb begin
    grant_id = 1'b0;
    case (req)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for two serial-bus masters and three slaves: decodes the
// 2-bit select prefix, routes the owner to the chosen slave, watchdogs the hold time.
module rr_bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_request,
  input  logic       m1_address,
  input  logic       m1_data,
  input  logic       m1_valid,
  input  logic       m1_address_valid,
  input  logic       m1_write_en,
  input  logic       m1_burst,
  input  logic       m2_request,
  input  logic       m2_address,
  input  logic       m2_data,
  input  logic       m2_valid,
  input  logic       m2_address_valid,
  input  logic       m2_write_en,
  input  logic       m2_burst,
  input  logic       s1_data_in,
  input  logic       s1_ready,
  input  logic       s1_valid_out,
  input  logic       s2_data_in,
  input  logic       s2_ready,
  input  logic       s2_valid_out,
  input  logic       s3_data_in,
  input  logic       s3_ready,
  input  logic       s3_valid_out,
  output logic       m1_available,
  output logic       m1_ready,
  output logic       m1_data_out,
  output logic       m1_valid_in,
  output logic       m2_available,
  output logic       m2_ready,
  output logic       m2_data_out,
  output logic       m2_valid_in,
  output logic       s1_address,
  output logic       s1_data,
  output logic       s1_valid,
  output logic       s1_write_en,
  output logic       s1_burst,
  output logic       s2_address,
  output logic       s2_data,
  output logic       s2_valid,
  output logic       s2_write_en,
  output logic       s2_burst,
  output logic       s3_address,
  output logic       s3_data,
  output logic       s3_valid,
  output logic       s3_write_en,
  output logic       s3_burst,
  output logic       decode_err,
  output logic       timeout,
  output logic [2:0] state
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          st;
  logic [1:0]      owner;
  logic            rr_last;
  logic [1:0]      sel;
  logic [1:0]      bitcnt;
  logic [TO_W-1:0] to_cnt;
  logic            grant_id;

  logic o_req, o_addr, o_data, o_valid, o_av, o_we, o_burst;
  logic r_ready, r_data, r_valid;
  logic connect;

  rr_picker u_picker (
    .req      ({m2_request, m1_request}),
    .last     (rr_last),
    .grant_id (grant_id)
  );

  always_comb begin
    o_req   = 1'b0;
    o_addr  = 1'b0;
    o_data  = 1'b0;
    o_valid = 1'b0;
    o_av    = 1'b0;
    o_we    = 1'b0;
    o_burst = 1'b0;
    if (owner == OWNER_M1) begin
      o_req   = m1_request;
      o_addr  = m1_address;
      o_data  = m1_data;
      o_valid = m1_valid;
      o_av    = m1_address_valid;
      o_we    = m1_write_en;
      o_burst = m1_burst;
    end else if (owner == OWNER_M2) begin
      o_req   = m2_request;
      o_addr  = m2_address;
      o_data  = m2_data;
      o_valid = m2_valid;
      o_av    = m2_address_valid;
      o_we    = m2_write_en;
      o_burst = m2_burst;
    end
  end

  // The second select bit is taken straight from the line, so the decision
  // lands on the same edge that samples it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= ST_IDLE;
      owner   <= OWNER_NONE;
      rr_last <= 1'b1;
      sel     <= SEL_S1;
      bitcnt  <= 2'd0;
      to_cnt  <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (m1_request || m2_request) begin
            owner  <= grant_id ? OWNER_M2 : OWNER_M1;
            bitcnt <= 2'd0;
            sel    <= SEL_S1;
            st     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (!o_req) begin
            st <= ST_RELEASE;
          end else if (o_av) begin
            sel    <= {sel[0], o_addr};
            bitcnt <= bitcnt + 2'd1;
            if (bitcnt == 2'd1) begin
              to_cnt <= '0;
              st     <= ({sel[0], o_addr} == SEL_BAD) ? ST_ERROR : ST_CONNECT;
            end
          end
        end
        ST_CONNECT: begin
          to_cnt <= to_cnt + 1'b1;
          if (!o_req || to_cnt == TO_LAST) st <= ST_RELEASE;
        end
        ST_ERROR: st <= ST_RELEASE;
        ST_RELEASE: begin
          rr_last <= (owner == OWNER_M2);
          owner   <= OWNER_NONE;
          to_cnt  <= '0;
          st      <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign connect = (st == ST_CONNECT);

  always_comb begin
    s1_address = 1'b0; s1_data = 1'b0; s1_valid = 1'b0; s1_write_en = 1'b0; s1_burst = 1'b0;
    s2_address = 1'b0; s2_data = 1'b0; s2_valid = 1'b0; s2_write_en = 1'b0; s2_burst = 1'b0;
    s3_address = 1'b0; s3_data = 1'b0; s3_valid = 1'b0; s3_write_en = 1'b0; s3_burst = 1'b0;
    r_ready = 1'b0;
    r_data  = 1'b0;
    r_valid = 1'b0;
    if (connect) begin
      case (sel)
        SEL_S1: begin
          s1_address = o_addr; s1_data = o_data; s1_valid = o_valid;
          s1_write_en = o_we;  s1_burst = o_burst;
          r_ready = s1_ready;  r_data = s1_data_in; r_valid = s1_valid_out;
        end
        SEL_S2: begin
          s2_address = o_addr; s2_data = o_data; s2_valid = o_valid;
          s2_write_en = o_we;  s2_burst = o_burst;
          r_ready = s2_ready;  r_data = s2_data_in; r_valid = s2_valid_out;
        end
        SEL_S3: begin
          s3_address = o_addr; s3_data = o_data; s3_valid = o_valid;
          s3_write_en = o_we;  s3_burst = o_burst;
          r_ready = s3_ready;  r_data = s3_data_in; r_valid = s3_valid_out;
        end
        default: ;
      endcase
    end
  end

  assign m1_available = (owner == OWNER_M1) && (st == ST_ADDR || connect);
  assign m2_available = (owner == OWNER_M2) && (st == ST_ADDR || connect);
  assign m1_ready     = connect && (owner == OWNER_M1) && r_ready;
  assign m1_data_out  = connect && (owner == OWNER_M1) && r_data;
  assign m1_valid_in  = connect && (owner == OWNER_M1) && r_valid;
  assign m2_ready     = connect && (owner == OWNER_M2) && r_ready;
  assign m2_data_out  = connect && (owner == OWNER_M2) && r_data;
  assign m2_valid_in  = connect && (owner == OWNER_M2) && r_valid;

  assign decode_err = (st == ST_ERROR);
  assign timeout    = connect && (to_cnt == TO_LAST);
  assign state      = st;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter: reset, tie-break, fairness, decode error,
// read path, hold timeout and asynchronous reset mid-transfer.
module tb_rr_bus_arbiter;
  import bus_pkg::*;

  logic clk;
  logic reset;
  logic m1_request, m1_address, m1_data, m1_valid, m1_address_valid, m1_write_en, m1_burst;
  logic m2_request, m2_address, m2_data, m2_valid, m2_address_valid, m2_write_en, m2_burst;
  logic s1_data_in, s1_ready, s1_valid_out;
  logic s2_data_in, s2_ready, s2_valid_out;
  logic s3_data_in, s3_ready, s3_valid_out;
  logic m1_available, m1_ready, m1_data_out, m1_valid_in;
  logic m2_available, m2_ready, m2_data_out, m2_valid_in;
  logic s1_address, s1_data, s1_valid, s1_write_en, s1_burst;
  logic s2_address, s2_data, s2_valid, s2_write_en, s2_burst;
  logic s3_address, s3_data, s3_valid, s3_write_en, s3_burst;
  logic decode_err, timeout;
  logic [2:0] state;

  int num_checks = 0;
  int num_errors = 0;

  rr_bus_arbiter #(.TIMEOUT(16), .TO_W(4)) dut (
    .clk(clk), .reset(reset),
    .m1_request(m1_request), .m1_address(m1_address), .m1_data(m1_data), .m1_valid(m1_valid),
    .m1_address_valid(m1_address_valid), .m1_write_en(m1_write_en), .m1_burst(m1_burst),
    .m2_request(m2_request), .m2_address(m2_address), .m2_data(m2_data), .m2_valid(m2_valid),
    .m2_address_valid(m2_address_valid), .m2_write_en(m2_write_en), .m2_burst(m2_burst),
    .s1_data_in(s1_data_in), .s1_ready(s1_ready), .s1_valid_out(s1_valid_out),
    .s2_data_in(s2_data_in), .s2_ready(s2_ready), .s2_valid_out(s2_valid_out),
    .s3_data_in(s3_data_in), .s3_ready(s3_ready), .s3_valid_out(s3_valid_out),
    .m1_available(m1_available), .m1_ready(m1_ready), .m1_data_out(m1_data_out), .m1_valid_in(m1_valid_in),
    .m2_available(m2_available), .m2_ready(m2_ready), .m2_data_out(m2_data_out), .m2_valid_in(m2_valid_in),
    .s1_address(s1_address), .s1_data(s1_data), .s1_valid(s1_valid), .s1_write_en(s1_write_en), .s1_burst(s1_burst),
    .s2_address(s2_address), .s2_data(s2_data), .s2_valid(s2_valid), .s2_write_en(s2_write_en), .s2_burst(s2_burst),
    .s3_address(s3_address), .s3_data(s3_data), .s3_valid(s3_valid), .s3_write_en(s3_write_en), .s3_burst(s3_burst),
    .decode_err(decode_err), .timeout(timeout), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [4:0]  s1_bits = {s1_address, s1_data, s1_valid, s1_write_en, s1_burst};
  wire [4:0]  s2_bits = {s2_address, s2_data, s2_valid, s2_write_en, s2_burst};
  wire [4:0]  s3_bits = {s3_address, s3_data, s3_valid, s3_write_en, s3_burst};
  wire [14:0] s_all   = {s1_bits, s2_bits, s3_bits};
  wire [24:0] all_out = {m1_available, m2_available, m1_ready, m1_data_out, m1_valid_in,
                         m2_ready, m2_data_out, m2_valid_in, s_all, decode_err, timeout};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int m, input logic req, input logic av, input logic addr,
                               input logic data, input logic valid, input logic we, input logic burst);
    if (m == 1) begin
      m1_request = req; m1_address_valid = av; m1_address = addr;
      m1_data = data; m1_valid = valid; m1_write_en = we; m1_burst = burst;
    end else begin
      m2_request = req; m2_address_valid = av; m2_address = addr;
      m2_data = data; m2_valid = valid; m2_write_en = we; m2_burst = burst;
    end
  endtask

  task automatic setSlaves(input logic [2:0] data_in, input logic [2:0] ready, input logic [2:0] valid_out);
    {s1_data_in, s2_data_in, s3_data_in}       = data_in;
    {s1_ready, s2_ready, s3_ready}             = ready;
    {s1_valid_out, s2_valid_out, s3_valid_out} = valid_out;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances until either master holds a grant; an expired budget is a failure.
  task automatic waitGrant(input string tag);
    for (int i = 0; i < 6 && !(m1_available || m2_available); i++) tick();
    checkOutput(tag, 32'(m1_available || m2_available), 1);
  endtask

  // Sends the two select bits; leaves the bench in the first post-select cycle.
  task automatic sendSelect(input int m, input logic [1:0] code);
    applyStimulus(m, 1'b1, 1'b1, code[1], 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(m, 1'b1, 1'b1, code[0], 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(m, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0]        r;
    logic [MADDR_W-1:0] word;
    logic [7:0]         rd_byte;
    int                 fair_order [4];

    // Reset held with random inputs
    reset = 1'b0;
    r = $urandom;
    {m1_request, m1_address, m1_data, m1_valid, m1_address_valid, m1_write_en, m1_burst} = r[6:0];
    {m2_request, m2_address, m2_data, m2_valid, m2_address_valid, m2_write_en, m2_burst} = r[13:7];
    {s1_data_in, s1_ready, s1_valid_out, s2_data_in, s2_ready, s2_valid_out,
     s3_data_in, s3_ready, s3_valid_out} = r[22:14];
    #3;
    tick();
    checkOutput("reset_outputs", 32'(all_out), 0);
    checkOutput("reset_state", 32'(state), 0);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 0);
    setSlaves(3'b000, 3'b000, 3'b000);
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    checkOutput("idle_no_req", 32'(state), 0);

    // Tie-break: m1 wins first, addresses s2 with a write
    word = 14'b01_0000_0000_0101;
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 0);
    applyStimulus(2, 1, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("tie_state", 32'(state), 1);
    checkOutput("tie_m1_avail", 32'(m1_available), 1);
    checkOutput("tie_m2_avail", 32'(m2_available), 0);
    for (int i = MADDR_W - 1; i >= SADDR_W; i--) begin
      applyStimulus(1, 1, 1, word[i], 1, 1, 1, 0);
      #1;
      checkOutput("addr_no_slave", 32'(s_all), 0);
      tick();
    end
    checkOutput("tie_connect", 32'(state), 2);
    for (int i = SADDR_W - 1; i >= 0; i--) begin
      applyStimulus(1, 1, 1, word[i], 1, 1, 1, 0);
      #1;
      checkOutput("s2_addr_bit", 32'(s2_address), 32'(word[i]));
      checkOutput("s2_we", 32'(s2_write_en), 1);
      checkOutput("s1_s3_quiet", 32'({s1_bits, s3_bits}), 0);
      tick();
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("tie_release", 32'(state), 4);
    checkOutput("release_quiet", 32'(all_out), 0);
    tick();
    checkOutput("tie_idle", 32'(state), 0);
    tick();
    checkOutput("m2_granted", 32'(m2_available), 1);
    checkOutput("m2_grant_m1", 32'(m1_available), 0);

    // Decode error: m2 sends select 11
    applyStimulus(2, 1, 1, 1, 1, 1, 1, 1);
    #1;
    checkOutput("err_addr_quiet", 32'(s_all), 0);
    tick();
    tick();
    checkOutput("err_state", 32'(state), 3);
    checkOutput("err_pulse", 32'(decode_err), 1);
    checkOutput("err_slaves", 32'(s_all), 0);
    applyStimulus(2, 1, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("err_release", 32'(state), 4);
    checkOutput("err_pulse_end", 32'(decode_err), 0);
    tick();
    checkOutput("err_idle", 32'(state), 0);

    // Fairness: both hold request, short transfers to s1
    fair_order = '{1, 2, 1, 2};
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    for (int t = 0; t < 4; t++) begin
      waitGrant("fair_grant_seen");
      checkOutput("fair_grant", m2_available ? 32'd2 : 32'd1, 32'(fair_order[t]));
      sendSelect(fair_order[t], SEL_S1);
      applyStimulus(fair_order[t], 1, 0, 0, 0, 1, 0, 0);
      #1;
      checkOutput("fair_s1_valid", 32'(s1_valid), 1);
      applyStimulus(fair_order[t], 0, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("fair_release", 32'(state), 4);
      applyStimulus(fair_order[t], 1, 0, 0, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 0);

    // Read path: m1 reads 8'hA5 from s3
    rd_byte = 8'hA5;
    waitGrant("rd_grant_seen");
    checkOutput("rd_m1_avail", 32'(m1_available), 1);
    sendSelect(1, SEL_S3);
    checkOutput("rd_connect", 32'(state), 2);
    for (int i = 7; i >= 0; i--) begin
      setSlaves({~rd_byte[i], ~rd_byte[i], rd_byte[i]}, 3'b001, 3'b001);
      #1;
      checkOutput("rd_data", 32'(m1_data_out), 32'(rd_byte[i]));
      checkOutput("rd_valid", 32'(m1_valid_in), 1);
      checkOutput("rd_ready", 32'(m1_ready), 1);
      checkOutput("rd_m2_quiet", 32'({m2_ready, m2_data_out, m2_valid_in}), 0);
      tick();
    end
    setSlaves(3'b000, 3'b000, 3'b000);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("rd_release", 32'(state), 4);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    tick();

    // Timeout: m1 holds s2 for the full window
    waitGrant("to_grant_seen");
    checkOutput("to_m1_avail", 32'(m1_available), 1);
    sendSelect(1, SEL_S2);
    for (int c = 1; c <= 16; c++) begin
      checkOutput("to_pulse", 32'(timeout), 32'(c == 16));
      checkOutput("to_avail", 32'(m1_available), 1);
      if (c < 16) tick();
    end
    tick();
    checkOutput("to_drop_avail", 32'(m1_available), 0);
    checkOutput("to_release", 32'(state), 4);
    checkOutput("to_pulse_end", 32'(timeout), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Asynchronous reset during a CONNECT to s1
    applyStimulus(2, 1, 0, 0, 0, 0, 0, 0);
    waitGrant("ar_grant_seen");
    sendSelect(2, SEL_S1);
    applyStimulus(2, 1, 0, 0, 1, 1, 1, 0);
    #1;
    checkOutput("ar_s1_valid", 32'(s1_valid), 1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("ar_outputs", 32'(all_out), 0);
    checkOutput("ar_state", 32'(state), 0);
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Round-robin, decoding arbiter for the serial bus. It grants one of two masters, strips the 2-bit slave-select prefix from the master's serial address, and routes that master's 1-bit lines to one of three slaves. It frees a hung transfer with a hold-timeout watchdog. It replaces the fixed-priority arbiter between the masters and slaves in the top level.

## Interface
- TIMEOUT, 4096: maximum cycles a master may hold the bus in CONNECT.
- TO_W, 12: width of the timeout counter; must satisfy 2^TO_W ≥ TIMEOUT.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mN_request, mN_address, mN_data, mN_valid, mN_address_valid, mN_write_en, mN_burst  in  1 each (N=1,2)  master bus request and serial lines.
- sK_data_in, sK_ready, sK_valid_out  in  1 each (K=1..3)  slave return lines.
- mN_available  out  1  grant to master N.
- mN_ready, mN_data_out, mN_valid_in  out  1 each  routed slave return lines.
- sK_address, sK_data, sK_valid, sK_write_en, sK_burst  out  1 each  routed master lines.
- decode_err  out  1  one-cycle pulse: select code 11 received.
- timeout  out  1  one-cycle pulse: hold watchdog fired.
- state  out  3  current FSM state.

## Operation
- States: IDLE=0, ADDR=1, CONNECT=2, ERROR=3, RELEASE=4.
- Registers: `owner` (1 = m1, 2 = m2), `rr_last` (last served master), `sel[1:0]`, `bitcnt[1:0]`, `to_cnt[TO_W-1:0]`.
- **IDLE**
  - One requester: grant it.
  - Both requesting: grant the master other than `rr_last`.
  - Go to ADDR and clear `bitcnt`.
- **ADDR**
  - `mowner_available` = 1.
  - On each edge with `mowner_address_valid` = 1, shift `mowner_address` MSB-first into `sel` and increment `bitcnt`.
  - After the 2nd bit: `sel` = 00/01/10 goes to CONNECT (s1/s2/s3); `sel` = 11 goes to ERROR.
  - No slave outputs are driven in ADDR.
- **CONNECT**
  - Combinationally route `mowner_{address, data, valid, address_valid→none, write_en, burst}` to `s[sel]_{address, data, valid, write_en, burst}`.
  - Route `s[sel]_{ready, data_in, valid_out}` to `mowner_{ready, data_out, valid_in}`.
  - `to_cnt` increments every cycle.
  - Exit to RELEASE when `mowner_request` = 0 or `to_cnt` = TIMEOUT−1.
  - If the timeout condition ends CONNECT, pulse `timeout`.
- **ERROR**: `decode_err` = 1 for this one cycle, then RELEASE.
- **RELEASE**: all outputs 0 for one cycle; `rr_last` ← `owner`; then IDLE.
- Owner drops `mowner_request` in ADDR: go to RELEASE.
- Non-owner and non-selected outputs: always 0.
- Reset: state=IDLE, `owner`=0, `rr_last`=m2 (so m1 wins the first tie), `sel`=0, `bitcnt`=0, `to_cnt`=0. Every output is 0.
- Reset asserted mid-transfer: all outputs go to 0 immediately (asynchronous) and the FSM returns to IDLE.

## Timing
- Grant latency: request sampled high at edge e gives `available` = 1 after e.
- The address select bit sampled at edge e+k (k ≥ 1) gives CONNECT after the edge that samples the 2nd bit. The 3rd address bit, presented in the following cycle, reaches the slave in that same cycle (combinational path, zero added latency).
- Return path (slave to master) is combinational in CONNECT.
- Minimum bus turnaround: one RELEASE cycle between owners. Back-to-back grants therefore alternate when both masters hold request.
- `decode_err` and `timeout` are registered-state decodes and are glitch-free.
- A request that rises in the RELEASE cycle is evaluated in IDLE on the next edge.

## Structure
- Shared package `bus_pkg`:
  - state encodings;
  - select codes SEL_S1=00, SEL_S2=01, SEL_S3=10, SEL_BAD=11;
  - master address width 14 and slave address width 12.
- Sub-module `rr_picker`: 2-way round-robin choice.
  - Inputs: `req[1:0]`, `last`.
  - Output: `grant_id`.
  - Purely combinational; used in IDLE.
- Remaining logic: one FSM always block plus a combinational routing mux, roughly 250 lines.

## Test plan
- **Reset**: reset=0 with random inputs; all outputs 0 and `state`=0; release reset, no requests; `state` stays 0.
- **Tie-break**: m1 and m2 request simultaneously after reset.
  - m1 granted first; m1 sends address 01_0000_0000_0101 and a write.
  - s2 receives serial 0000_0000_0101; s1/s3 lines stay 0.
  - m1 drops request: 1 RELEASE cycle, then m2 is granted.
- **Fairness**: m1 and m2 both assert request continuously with short transfers; grants alternate m1, m2, m1, m2 over 4 transfers.
- **Decode error**: m2 sends select 11; `decode_err` pulses once; no slave line toggles; FSM goes to IDLE 2 cycles later.
- **Timeout**: TIMEOUT=16; m1 holds request in CONNECT; `timeout` pulses at the 16th CONNECT cycle; m1_available drops the next cycle.
- **Read path**: m1 reads from s3 (select 10). s3 drives ready=1, valid_out=1 and data_in 8'hA5 serially; m1_valid_in and m1_data_out show the same bits in the same cycles.
